// File: rtl/cnt_4b_if.sv
// cnt_4b_if: control, bound and status signals of the cnt_4b counter.
// CNT_4B_SHIFT_REG_EN adds the serial-in/parallel-out shift register signals.
interface cnt_4b_if;
    logic       i_ss;
    logic       i_mode;
    logic [3:0] i_max;
    logic [3:0] i_min;
    logic [3:0] o_out;
    logic       o_tc;
`ifdef CNT_4B_SHIFT_REG_EN
    logic       i_in;
    logic [3:0] o_q;
    modport master (output i_ss, i_mode, i_max, i_min, i_in, input o_out, o_tc, o_q);
    modport slave  (input i_ss, i_mode, i_max, i_min, i_in, output o_out, o_tc, o_q);
`else
    modport master (output i_ss, i_mode, i_max, i_min, input o_out, o_tc);
    modport slave  (input i_ss, i_mode, i_max, i_min, output o_out, o_tc);
`endif
endinterface

// File: rtl/cnt_4b.sv
// cnt_4b: bounded 4-bit up/down counter with terminal-count pulse.
// CNT_4B_SHIFT_REG_EN adds a 4-bit serial-in/parallel-out shift register.
module cnt_4b (
    input  logic     clk,
    input  logic     rst,
    cnt_4b_if.slave  bus
);
    logic [3:0] r_out;
    logic       r_tc;
    logic       w_bad;
    logic       w_up_wrap;
    logic       w_dn_wrap;
    logic       w_wrap;
    logic [3:0] w_nxt;

    assign w_bad     = bus.i_min > bus.i_max;
    assign w_up_wrap = (r_out >= bus.i_max) || (r_out < bus.i_min);
    assign w_dn_wrap = (r_out <= bus.i_min) || (r_out > bus.i_max);

    always_comb begin
        w_wrap = bus.i_mode ? w_dn_wrap : w_up_wrap;
        w_nxt  = bus.i_mode ? (w_dn_wrap ? bus.i_max : r_out - 4'd1)
                            : (w_up_wrap ? bus.i_min : r_out + 4'd1);
    end

    always_ff @(posedge clk) begin
        if (rst || w_bad) begin
            r_out <= bus.i_min;
            r_tc  <= 1'b0;
        end else if (!bus.i_ss) begin
            r_tc  <= 1'b0;
        end else begin
            r_out <= w_nxt;
            r_tc  <= w_wrap;
        end
    end

    assign bus.o_out = r_out;
    assign bus.o_tc  = r_tc;

`ifdef CNT_4B_SHIFT_REG_EN
    logic [3:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) r_q <= 4'b0000;
        else     r_q <= {r_q[2:0], bus.i_in};
    end

    assign bus.o_q = r_q;
`endif
endmodule

// File: tb/tb_cnt_4b.sv
// tb_cnt_4b: directed self-checking bench for cnt_4b.
module tb_cnt_4b;
    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_fail = 0;

    cnt_4b_if bus ();
    cnt_4b dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic [3:0] e_out, input logic e_tc);
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".out"}, bus.o_out, e_out);
        chk({tag, ".tc"}, {3'b0, bus.o_tc}, {3'b0, e_tc});
    endtask

    initial begin
        rst = 1'b1;
        bus.i_ss = 1'b1;
        bus.i_mode = 1'b0;
        bus.i_min = 4'd9;
        bus.i_max = 4'd14;
`ifdef CNT_4B_SHIFT_REG_EN
        bus.i_in = 1'b0;
`endif
        step("rst", 4'd9, 1'b0);
`ifdef CNT_4B_SHIFT_REG_EN
        chk("rst.q", bus.o_q, 4'b0000);
`endif
        rst = 1'b0;
        step("up10", 4'd10, 1'b0);
        step("up11", 4'd11, 1'b0);
        step("up12", 4'd12, 1'b0);
        step("up13", 4'd13, 1'b0);
        step("up14", 4'd14, 1'b0);
        step("upwrap", 4'd9, 1'b1);
        step("up10b", 4'd10, 1'b0);
        step("up11b", 4'd11, 1'b0);
        step("up12b", 4'd12, 1'b0);
        step("up13b", 4'd13, 1'b0);
        step("up14b", 4'd14, 1'b0);
        step("upwrap2", 4'd9, 1'b1);
        bus.i_mode = 1'b1;
        step("dnwrap", 4'd14, 1'b1);
        step("dn13", 4'd13, 1'b0);
        step("dn12", 4'd12, 1'b0);
        step("dn11", 4'd11, 1'b0);
        bus.i_ss = 1'b0;
        step("hold1", 4'd11, 1'b0);
        step("hold2", 4'd11, 1'b0);
        step("hold3", 4'd11, 1'b0);
        bus.i_ss = 1'b1;
        bus.i_mode = 1'b0;
        step("resume", 4'd12, 1'b0);
        step("up13c", 4'd13, 1'b0);
        bus.i_max = 4'd10;
        step("maxdrop", 4'd9, 1'b1);
        bus.i_min = 4'd12;
        bus.i_max = 4'd5;
        step("bad1", 4'd12, 1'b0);
        bus.i_mode = 1'b1;
        step("bad2", 4'd12, 1'b0);
        bus.i_min = 4'd9;
        bus.i_max = 4'd14;
        step("rev11", 4'd11, 1'b0);
        bus.i_mode = 1'b0;
        step("rev12", 4'd12, 1'b0);
        rst = 1'b1;
        step("midrst", 4'd9, 1'b0);
        rst = 1'b0;
        bus.i_mode = 1'b1;
        step("postrst", 4'd14, 1'b1);
        bus.i_mode = 1'b0;
        bus.i_min = 4'd5;
        bus.i_max = 4'd5;
        step("eq1", 4'd5, 1'b1);
        step("eq2", 4'd5, 1'b1);
        bus.i_mode = 1'b1;
        step("eq3", 4'd5, 1'b1);
        bus.i_ss = 1'b0;
        step("eqhold", 4'd5, 1'b0);
`ifdef CNT_4B_SHIFT_REG_EN
        rst = 1'b1;
        step("rst2", 4'd5, 1'b0);
        chk("rst2.q", bus.o_q, 4'b0000);
        rst = 1'b0;
        bus.i_in = 1'b1; step("sr1", 4'd5, 1'b0); chk("sr1.q", bus.o_q, 4'b0001);
        bus.i_in = 1'b1; step("sr2", 4'd5, 1'b0); chk("sr2.q", bus.o_q, 4'b0011);
        bus.i_in = 1'b0; step("sr3", 4'd5, 1'b0); chk("sr3.q", bus.o_q, 4'b0110);
        step("sr4", 4'd5, 1'b0); chk("sr4.q", bus.o_q, 4'b1100);
        step("sr5", 4'd5, 1'b0); chk("sr5.q", bus.o_q, 4'b1000);
        step("sr6", 4'd5, 1'b0); chk("sr6.q", bus.o_q, 4'b0000);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
